// File: rtl/x1_crtc.sv
// x1_crtc: HD46505-compatible CRTC generating character/raster timing, refresh address, sync and blank.
// Optional hardware cursor with blink is enabled by defining X1_CRTC_CURSOR_EN.
module x1_crtc #(
    parameter int MA_W      = 14,
    parameter int RA_W      = 5,
    parameter int BLINK_DIV = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce_char,
    input  logic            cs,
    input  logic            a0,
    input  logic            wr,
    input  logic            rd,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic [MA_W-1:0] ma,
    output logic [RA_W-1:0] ra,
    output logic            de,
    output logic            hblank,
    output logic            vblank,
    output logic            hsync,
    output logic            vsync,
    output logic            cursor
);
    typedef enum logic {ACTIVE, ADJUST} state_t;

    logic [7:0]      regs_q [16];
    logic [4:0]      addr_q;
    state_t          state_q, state_d;
    logic [7:0]      hc_q, hc_d;
    logic [RA_W-1:0] ra_q, ra_d;
    logic [6:0]      row_q, row_d;
    logic [MA_W-1:0] ma_row_q, ma_row_d, ma_q, ma_d;
    logic [4:0]      adj_q, adj_d, hs_q, hs_d, vs_q, vs_d;
    logic            hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
    logic            eol, last_row, frame_end, vs_start;
    logic [4:0]      hs_w, vs_w;
    logic            unused_bits;

    assign eol      = hc_q >= regs_q[0];
    assign last_row = row_q >= regs_q[4][6:0];
    assign hs_w     = (regs_q[3][3:0] == 4'd0) ? 5'd16 : {1'b0, regs_q[3][3:0]};
    assign vs_w     = (regs_q[3][7:4] == 4'd0) ? 5'd16 : {1'b0, regs_q[3][7:4]};

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        row_d     = row_q;
        ma_row_d  = ma_row_q;
        adj_d     = adj_q;
        frame_end = 1'b0;
        hc_d      = eol ? 8'd0 : hc_q + 8'd1;
        if (eol) begin
            if (state_q == ADJUST) begin
                if (adj_q + 5'd1 >= regs_q[5][4:0]) frame_end = 1'b1;
                else begin
                    adj_d = adj_q + 5'd1;
                    ra_d  = ra_q + 1'b1;
                end
            end else if (ra_q >= regs_q[9][RA_W-1:0]) begin
                if (last_row && regs_q[5][4:0] == 5'd0) frame_end = 1'b1;
                else begin
                    ra_d     = '0;
                    row_d    = row_q + 7'd1;
                    ma_row_d = ma_row_q + MA_W'(regs_q[1]);
                    if (last_row) begin
                        state_d = ADJUST;
                        adj_d   = 5'd0;
                    end
                end
            end else ra_d = ra_q + 1'b1;
        end
        if (frame_end) begin
            state_d  = ACTIVE;
            ra_d     = '0;
            row_d    = 7'd0;
            ma_row_d = MA_W'({regs_q[12][5:0], regs_q[13]});
        end
        // A line wrap drops any hsync still pending unless the new hc itself matches R2.
        hs_d     = (hc_d == regs_q[2]) ? hs_w : eol ? 5'd0 : (hs_q != 5'd0) ? hs_q - 5'd1 : 5'd0;
        vs_start = eol && ra_d == '0 && row_d == regs_q[7][6:0];
        vs_d     = vs_start ? vs_w : (eol && vs_q != 5'd0) ? vs_q - 5'd1 : vs_q;
        hblank_d = hc_d >= regs_q[1];
        vblank_d = row_d >= regs_q[6][6:0] || state_d == ADJUST;
        de_d     = !hblank_d && !vblank_d;
        ma_d     = ma_row_d + MA_W'(hc_d);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
            addr_q   <= 5'd0;
            state_q  <= ACTIVE;
            hc_q     <= 8'd0;
            ra_q     <= '0;
            row_q    <= 7'd0;
            ma_row_q <= '0;
            ma_q     <= '0;
            adj_q    <= 5'd0;
            hs_q     <= 5'd0;
            vs_q     <= 5'd0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            if (cs && wr && !a0) addr_q <= din[4:0];
            if (cs && wr && a0 && !addr_q[4]) regs_q[addr_q[3:0]] <= din;
            if (ce_char) begin
                state_q  <= state_d;
                hc_q     <= hc_d;
                ra_q     <= ra_d;
                row_q    <= row_d;
                ma_row_q <= ma_row_d;
                ma_q     <= ma_d;
                adj_q    <= adj_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
                hblank_q <= hblank_d;
                vblank_q <= vblank_d;
                de_q     <= de_d;
            end
        end
    end

    assign dout   = !(cs && rd && a0) ? 8'd0 :
                    (addr_q == 5'd14) ? {2'b00, regs_q[14][5:0]} :
                    (addr_q == 5'd15) ? regs_q[15] : 8'd0;
    assign ma     = ma_q;
    assign ra     = ra_q;
    assign de     = de_q;
    assign hblank = hblank_q;
    assign vblank = vblank_q;
    assign hsync  = hs_q != 5'd0;
    assign vsync  = vs_q != 5'd0;

`ifdef X1_CRTC_CURSOR_EN
    localparam int BW = $clog2(4 * BLINK_DIV);
    logic [BW-1:0] blink_q, blink_d;
    logic          blink_on, cursor_q, cursor_d;

    // One blink counter covers both rates: a 4*BLINK_DIV field cycle.
    always_comb begin
        blink_d  = !frame_end ? blink_q : (blink_q == BW'(4 * BLINK_DIV - 1)) ? '0 : blink_q + 1'b1;
        blink_on = (regs_q[10][6:5] == 2'b00) ? 1'b1 :
                   (regs_q[10][6:5] == 2'b01) ? 1'b0 :
                   (regs_q[10][6:5] == 2'b10) ? (blink_d < BW'(BLINK_DIV) ||
                       (blink_d >= BW'(2 * BLINK_DIV) && blink_d < BW'(3 * BLINK_DIV))) :
                   blink_d < BW'(2 * BLINK_DIV);
        cursor_d = de_d && ma_d == MA_W'({regs_q[14][5:0], regs_q[15]}) &&
                   ra_d >= RA_W'(regs_q[10][4:0]) && ra_d <= RA_W'(regs_q[11][4:0]) && blink_on;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            blink_q  <= '0;
            cursor_q <= 1'b0;
        end else if (ce_char) begin
            blink_q  <= blink_d;
            cursor_q <= cursor_d;
        end
    end

    assign cursor = cursor_q;
`else
    assign cursor = 1'b0;
`endif

    assign unused_bits = ^{regs_q[4], regs_q[5], regs_q[6], regs_q[7], regs_q[8], regs_q[9],
                           regs_q[10], regs_q[11], regs_q[12], regs_q[14]};
endmodule

// File: tb/tb_x1_crtc.sv
// tb_x1_crtc: directed checks of x1_crtc bus access, horizontal/vertical timing and address generation.
module tb_x1_crtc;
    logic        clk_sys = 1'b0, reset = 1'b1, ce_char = 1'b0;
    logic        cs = 1'b0, a0 = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0]  din = 8'd0, dout, rv;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de, hblank, vblank, hsync, vsync, cursor;
    int          checks = 0, failures = 0;

    always #5 clk_sys = ~clk_sys;

    x1_crtc dut (
        .clk_sys(clk_sys), .reset(reset), .ce_char(ce_char), .cs(cs), .a0(a0), .wr(wr), .rd(rd),
        .din(din), .dout(dout), .ma(ma), .ra(ra), .de(de), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .cursor(cursor)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys) reset = 1'b1;
        ce_char = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys) reset = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge clk_sys) {cs, wr, a0, din} = {1'b1, 1'b1, 1'b0, a};
        @(negedge clk_sys) {cs, wr} = 2'b00;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [7:0] d);
        set_addr(a);
        @(negedge clk_sys) {cs, wr, a0, din} = {1'b1, 1'b1, 1'b1, d};
        @(negedge clk_sys) {cs, wr, a0} = 3'b000;
    endtask

    task automatic rreg(input logic [7:0] a, output logic [7:0] v);
        set_addr(a);
        @(negedge clk_sys) {cs, rd, a0} = 3'b111;
        #1 v = dout;
        @(negedge clk_sys) {cs, rd, a0} = 3'b000;
    endtask

    task automatic tick();
        @(negedge clk_sys) ce_char = 1'b1;
        @(negedge clk_sys) ce_char = 1'b0;
    endtask

    initial begin
        int hc_m, ln_m, base_m, row_m, ra_m;
        do_reset();
        check("rst_ma", ma, 0);
        check("rst_ra", ra, 0);
        check("rst_sig", {de, hblank, vblank, hsync, vsync, cursor}, 0);
        check("rst_dout", dout, 0);
        rreg(14, rv);
        check("rst_r14", rv, 8'h00);
        wreg(14, 8'hC5);
        rreg(14, rv);
        check("rd_r14", rv, 8'h05);
        wreg(15, 8'hAB);
        rreg(15, rv);
        check("rd_r15", rv, 8'hAB);
        wreg(16, 8'h77);
        rreg(16, rv);
        check("rd_r16", rv, 8'h00);
        wreg(0, 8'h12);
        rreg(0, rv);
        check("rd_r0", rv, 8'h00);
        set_addr(15);
        @(negedge clk_sys) {cs, rd, a0} = 3'b110;
        #1 check("rd_a0_low", dout, 8'h00);
        @(negedge clk_sys) {cs, rd, a0} = 3'b000;

        // Horizontal: 56-character line, blank from 40, sync 45..48.
        do_reset();
        wreg(0, 55); wreg(1, 40); wreg(2, 45); wreg(3, 8'h34);
        hc_m = 0;
        for (int t = 0; t < 112; t++) begin
            tick();
            hc_m = (hc_m >= 55) ? 0 : hc_m + 1;
            check("h_ma", ma, hc_m);
            check("h_hblank", hblank, hc_m >= 40);
            check("h_hsync", hsync, hc_m >= 45 && hc_m <= 48);
        end

        // Vertical: 10 chars/line, 4 rows of 2 lines, 2 adjust lines, vsync row 1 for 2 lines.
        do_reset();
        wreg(0, 9); wreg(1, 8); wreg(2, 8); wreg(3, 8'h21); wreg(4, 3); wreg(5, 2);
        wreg(6, 3); wreg(7, 1); wreg(9, 1); wreg(12, 8'h01); wreg(13, 8'h00);
        hc_m = 0; ln_m = 0; base_m = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (hc_m >= 9) begin
                hc_m = 0;
                if (ln_m == 9) begin
                    ln_m   = 0;
                    base_m = 'h100;
                end else ln_m++;
            end else hc_m++;
            row_m = (ln_m < 8) ? ln_m / 2 : 4;
            ra_m  = (ln_m < 8) ? ln_m % 2 : ln_m - 8;
            check("v_ra", ra, ra_m);
            check("v_ma", ma, base_m + row_m * 8 + hc_m);
            check("v_vblank", vblank, ln_m >= 6);
            check("v_vsync", vsync, ln_m == 2 || ln_m == 3);
            check("v_de", de, hc_m < 8 && ln_m < 6);
            check("v_hblank", hblank, hc_m >= 8);
            check("v_hsync", hsync, hc_m == 8);
        end

        // Lowering R0 mid-line ends the line on the next character.
        do_reset();
        wreg(0, 55); wreg(1, 40);
        for (int t = 0; t < 50; t++) tick();
        check("mid_hc50", ma, 50);
        wreg(0, 30);
        tick();
        check("mid_wrap", ma, 0);
        for (int t = 0; t < 30; t++) tick();
        check("mid_hc30", ma, 30);
        tick();
        check("mid_wrap2", ma, 0);

        // Write coinciding with ce_char: this character still uses the old R0.
        do_reset();
        wreg(0, 55);
        for (int t = 0; t < 10; t++) tick();
        set_addr(0);
        @(negedge clk_sys) {cs, wr, a0, din, ce_char} = {1'b1, 1'b1, 1'b1, 8'd5, 1'b1};
        @(negedge clk_sys) {cs, wr, a0, ce_char} = 4'b0000;
        check("sim_old_r0", ma, 11);
        tick();
        check("sim_new_r0", ma, 0);
        tick();
        check("sim_next", ma, 1);

`ifdef X1_CRTC_CURSOR_EN
        // Steady cursor at 0x105, rasters 6..7; 16-line frames of 10 characters.
        do_reset();
        wreg(0, 9); wreg(1, 8); wreg(2, 8); wreg(3, 8'h11); wreg(4, 1); wreg(6, 2); wreg(9, 7);
        wreg(12, 8'h01); wreg(13, 8'h00); wreg(14, 8'h01); wreg(15, 8'h05);
        wreg(10, 8'h06); wreg(11, 8'h07);
        hc_m = 0; ln_m = 0; base_m = 0;
        for (int t = 0; t < 320; t++) begin
            tick();
            if (hc_m >= 9) begin
                hc_m = 0;
                if (ln_m == 15) begin
                    ln_m   = 0;
                    base_m = 'h100;
                end else ln_m++;
            end else hc_m++;
            check("c_steady", cursor, base_m == 'h100 && hc_m == 5 && (ln_m == 6 || ln_m == 7));
        end
        // Blink mode 10: visible in fields where field%32 < 16.
        do_reset();
        wreg(0, 9); wreg(1, 8); wreg(4, 1); wreg(6, 2); wreg(9, 7);
        wreg(12, 8'h01); wreg(13, 8'h00); wreg(14, 8'h01); wreg(15, 8'h05);
        wreg(10, 8'h46); wreg(11, 8'h07);
        for (int f = 0; f < 41; f++) begin
            int cnt;
            cnt = 0;
            for (int t = 0; t < 160; t++) begin
                tick();
                cnt += int'(cursor);
            end
            check("c_blink", cnt, (f > 0 && (f % 32) < 16) ? 2 : 0);
        end
`else
        check("c_off", cursor, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
